// File: rtl/des_key_scheduler.sv
// rtl/des_key_scheduler.sv - DES key schedule sequencer streaming PC-2 subkeys over valid/ready
module des_right_shifter (
  input  logic [27:0] din,
  input  logic [1:0]  amt,
  output logic [27:0] dout
);

  // Right rotation of a 28-bit half-key; din[27] is the first DES bit of the half
  always_comb begin
    dout = din;
    case (amt)
      2'd1:    dout = {din[0], din[27:1]};
      2'd2:    dout = {din[1:0], din[27:2]};
      default: dout = din;
    endcase
  end

endmodule

module des_key_scheduler #(
  parameter bit PARITY_CHECK = 1'b0,
  parameter bit ZERO_IDLE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        key_err,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic [3:0]  sk_round,
  output logic        sk_last,
  output logic        busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Table entries are 1-based DES bit numbers, first output bit first
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // key[63] is DES bit 1; result[55] is C bit 1, result[27] is D bit 1
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55 - i] = k[64 - PC1_TAB[i]];
    end
    return r;
  endfunction

  // cd[55] is DES bit 1 of the concatenated C,D; result[47] is subkey bit 1
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47 - i] = cd[56 - PC2_TAB[i]];
    end
    return r;
  endfunction

  function automatic logic odd_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ok = ok & (^k[8*i +: 8]);
    end
    return ok;
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        key_err_q, key_err_d;

  logic [55:0] pc1_cd;
  logic        parity_ok;
  logic [1:0]  rot_amt;
  logic [27:0] c_rl, d_rl;
  logic [27:0] c_rr, d_rr;
  logic [27:0] cs, ds;
  logic [47:0] pc2_out;
  logic        last;

  assign pc1_cd    = pc1(key);
  assign parity_ok = odd_parity_ok(key);
  assign last      = mode_q ? (round_q == 4'd0) : (round_q == 4'd15);

  // Per-round shift amount; decrypt undoes the encrypt shift of the following round
  always_comb begin
    rot_amt = 2'd2;
    if (mode_q) begin
      if (round_q == 4'd15) begin
        rot_amt = 2'd0;
      end else if (round_q == 4'd14 || round_q == 4'd7 || round_q == 4'd0) begin
        rot_amt = 2'd1;
      end
    end else begin
      if (round_q == 4'd0 || round_q == 4'd1 || round_q == 4'd8 || round_q == 4'd15) begin
        rot_amt = 2'd1;
      end
    end
  end

  des_right_shifter u_c_shift (
    .din  (c_q),
    .amt  (rot_amt),
    .dout (c_rr)
  );

  des_right_shifter u_d_shift (
    .din  (d_q),
    .amt  (rot_amt),
    .dout (d_rr)
  );

  // Left rotation of both halves for the encrypt direction
  always_comb begin
    c_rl = c_q;
    d_rl = d_q;
    case (rot_amt)
      2'd1: begin
        c_rl = {c_q[26:0], c_q[27]};
        d_rl = {d_q[26:0], d_q[27]};
      end
      2'd2: begin
        c_rl = {c_q[25:0], c_q[27:26]};
        d_rl = {d_q[25:0], d_q[27:26]};
      end
      default: begin
        c_rl = c_q;
        d_rl = d_q;
      end
    endcase
  end

  // Rotated halves for the current round and the subkey derived from them
  always_comb begin
    cs      = mode_q ? c_rr : c_rl;
    ds      = mode_q ? d_rr : d_rl;
    pc2_out = pc2({cs, ds});
  end

  // Next-state: abort wins, then key acceptance in IDLE, then subkey stepping in RUN
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    round_d   = round_q;
    mode_d    = mode_q;
    key_err_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_valid) begin
            if (PARITY_CHECK && !parity_ok) begin
              key_err_d = 1'b1;
            end else begin
              c_d     = pc1_cd[55:28];
              d_d     = pc1_cd[27:0];
              mode_d  = decrypt;
              round_d = decrypt ? 4'd15 : 4'd0;
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (sk_ready) begin
            c_d = cs;
            d_d = ds;
            if (last) begin
              state_d = S_IDLE;
            end else begin
              round_d = mode_q ? (round_q - 4'd1) : (round_q + 4'd1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      d_q       <= '0;
      round_q   <= '0;
      mode_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      d_q       <= d_d;
      round_q   <= round_d;
      mode_q    <= mode_d;
      key_err_q <= key_err_d;
    end
  end

  // Outputs decode from state so an asynchronous reset takes effect without a clock
  always_comb begin
    key_ready = (state_q == S_IDLE);
    sk_valid  = (state_q == S_RUN);
    busy      = (state_q == S_RUN);
    key_err   = PARITY_CHECK ? key_err_q : 1'b0;
    subkey    = pc2_out;
    sk_round  = round_q;
    sk_last   = last;
    if (ZERO_IDLE && (state_q != S_RUN)) begin
      subkey   = '0;
      sk_round = '0;
      sk_last  = 1'b0;
    end
  end

endmodule

// File: tb/tb_des_key_scheduler.sv
// tb/tb_des_key_scheduler.sv - scoreboard bench for des_key_scheduler against a cumulative-shift key schedule model
module tb_des_key_scheduler;

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BP = 64'h133457799BBCDFF0;
  localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, abort, key_valid, decrypt, sk_ready;
  logic [63:0] key;
  logic        key_ready, key_err, sk_valid, sk_last, busy;
  logic [47:0] subkey;
  logic [3:0]  sk_round;

  logic        abort_p, key_valid_p, decrypt_p, sk_ready_p;
  logic [63:0] key_p;
  logic        key_ready_p, key_err_p, sk_valid_p, sk_last_p, busy_p;
  logic [47:0] subkey_p;
  logic [3:0]  sk_round_p;

  des_key_scheduler dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .decrypt(decrypt), .key_err(key_err), .sk_valid(sk_valid), .sk_ready(sk_ready),
    .subkey(subkey), .sk_round(sk_round), .sk_last(sk_last), .busy(busy)
  );

  des_key_scheduler #(.PARITY_CHECK(1'b1), .ZERO_IDLE(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .abort(abort_p), .key_valid(key_valid_p), .key_ready(key_ready_p),
    .key(key_p), .decrypt(decrypt_p), .key_err(key_err_p), .sk_valid(sk_valid_p), .sk_ready(sk_ready_p),
    .subkey(subkey_p), .sk_round(sk_round_p), .sk_last(sk_last_p), .busy(busy_p)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  r;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] seen_sk [16];
  int          n_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Subkey K(n) from cumulative left shift of the PC-1 halves
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int n);
    logic [47:0] r;
    int tot, q, src;
    tot = 0;
    for (int i = 0; i < n; i++) tot += SHIFTS[i];
    r = '0;
    for (int m = 1; m <= 48; m++) begin
      q = PC2[m-1];
      if (q <= 28) src = PC1[(q - 1 + tot) % 28];
      else         src = PC1[28 + ((q - 29 + tot) % 28)];
      r[48 - m] = k[64 - src];
    end
    return r;
  endfunction

  task automatic push_schedule(input logic [63:0] k, input logic dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.r    = dec ? 4'(15 - i) : 4'(i);
      e.sk   = model_subkey(k, int'(e.r) + 1);
      e.last = (i == 15);
      sb.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on each subkey handshake and checks stall/idle behaviour
  logic        have_prev = 1'b0, expect_idle = 1'b0, expect_valid = 1'b0;
  logic [52:0] prev_out;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      have_prev    = 1'b0;
      expect_idle  = 1'b0;
      expect_valid = 1'b0;
    end else begin
      chk("key_err_tied0", 64'(key_err), 64'd0);
      if (expect_idle) begin
        chk("ready_after_last", 64'({key_ready, sk_valid}), 64'b10);
        expect_idle = 1'b0;
      end
      if (expect_valid) begin
        chk("valid_after_key", 64'({sk_valid, key_ready}), 64'b10);
        expect_valid = 1'b0;
      end
      if (have_prev && sk_valid) chk("stall_hold", 64'({subkey, sk_round, sk_last}), 64'(prev_out));
      have_prev = 1'b0;
      if (!sk_valid) chk("idle_zero", 64'({subkey, sk_round, sk_last, busy}), 64'd0);
      else           chk("busy_run", 64'(busy), 64'd1);
      if (abort) begin
        sb.delete();
      end else begin
        if (key_valid && key_ready) expect_valid = 1'b1;
        if (sk_valid && sk_ready) begin
          n_hs++;
          if (sb.size() == 0) begin
            chk("unexpected_subkey", 64'(sk_round), 64'hFFFF);
          end else begin
            e = sb.pop_front();
            chk("subkey", 64'(subkey), 64'(e.sk));
            chk("sk_round", 64'(sk_round), 64'(e.r));
            chk("sk_last", 64'(sk_last), 64'(e.last));
          end
          seen_sk[sk_round] = subkey;
          if (sk_last) begin
            expect_idle = 1'b1;
            chk("handshakes_per_key", 64'(sb.size()), 64'd0);
          end
        end else if (sk_valid) begin
          have_prev = 1'b1;
          prev_out  = {subkey, sk_round, sk_last};
        end
      end
    end
  end

  function automatic logic rnd_ready(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // Offers a key from IDLE (caller sits 1 time unit after a rising edge) and drains the schedule
  task automatic run_key(input logic [63:0] k, input logic dec, input int pct, output int cyc);
    chk("key_ready_idle", 64'(key_ready), 64'd1);
    key       = k;
    decrypt   = dec;
    key_valid = 1'b1;
    sk_ready  = rnd_ready(pct);
    @(posedge clk); #1;
    push_schedule(k, dec);
    key_valid = 1'b0;
    key       = {$urandom, $urandom};
    decrypt   = ~dec;
    cyc = 0;
    while (!key_ready && cyc < 400) begin
      sk_ready = rnd_ready(pct);
      @(posedge clk); #1;
      cyc++;
    end
    if (!key_ready) chk("drain_timeout", 64'(cyc), 64'd0);
    sk_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; abort = 1'b0; key_valid = 1'b0; decrypt = 1'b0; sk_ready = 1'b0; key = '0;
    abort_p = 1'b0; key_valid_p = 1'b0; decrypt_p = 1'b0; sk_ready_p = 1'b0; key_p = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_outputs", 64'({key_ready, sk_valid, key_err, busy, subkey, sk_round, sk_last}), 64'h1 << 56);

    // Encrypt, back-to-back
    run_key(KEY_A, 1'b0, 100, cyc);
    chk("enc_turnaround", 64'(cyc), 64'd16);
    chk("enc_k1", 64'(seen_sk[0]), 64'(K1_A));
    chk("enc_k16", 64'(seen_sk[15]), 64'(K16_A));

    // Decrypt, back-to-back
    n_hs = 0;
    run_key(KEY_A, 1'b1, 100, cyc);
    chk("dec_turnaround", 64'(cyc), 64'd16);
    chk("dec_k16", 64'(seen_sk[15]), 64'(K16_A));
    chk("dec_k1", 64'(seen_sk[0]), 64'(K1_A));
    chk("dec_hs_count", 64'(n_hs), 64'd16);

    // Decrypt with a sparse ready
    n_hs = 0;
    run_key(KEY_A, 1'b1, 30, cyc);
    chk("dec30_hs_count", 64'(n_hs), 64'd16);

    // Random keys, directions and ready densities
    for (int i = 0; i < 12; i++) begin
      run_key({$urandom, $urandom}, 1'($urandom_range(1)), int'($urandom_range(100, 25)), cyc);
      if ($urandom_range(1) == 1) begin
        @(posedge clk); #1;
      end
    end

    // Abort mid-schedule at round 5
    key = KEY_A; decrypt = 1'b0; key_valid = 1'b1; sk_ready = 1'b1;
    @(posedge clk); #1;
    push_schedule(KEY_A, 1'b0);
    key_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_round", 64'({sk_valid, sk_round}), 64'h15);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; sk_ready = 1'b0;
    chk("abort_to_idle", 64'({sk_valid, key_ready, busy}), 64'b010);
    seen_sk[0] = '0;
    run_key(KEY_A, 1'b0, 100, cyc);
    chk("restart_k1", 64'(seen_sk[0]), 64'(K1_A));

    // Abort together with a key offer discards the key; abort in IDLE is harmless
    key = KEY_A; key_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; abort = 1'b0;
    chk("abort_key_discard", 64'({sk_valid, key_ready}), 64'b01);
    @(posedge clk); #1;
    chk("abort_key_still_idle", 64'({sk_valid, key_ready}), 64'b01);

    // Asynchronous reset mid-schedule
    key = KEY_A; decrypt = 1'b1; key_valid = 1'b1; sk_ready = 1'b1;
    @(posedge clk); #1;
    push_schedule(KEY_A, 1'b1);
    key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 64'({key_ready, sk_valid, key_err, busy, subkey, sk_round, sk_last}), 64'h1 << 56);
    sk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 64'({key_ready, sk_valid}), 64'b10);
    run_key(KEY_A, 1'b0, 60, cyc);

    // Parity-checking instance
    key_p = KEY_BP; decrypt_p = 1'b0; key_valid_p = 1'b1;
    chk("par_ready", 64'(key_ready_p), 64'd1);
    @(posedge clk); #1;
    key_valid_p = 1'b0;
    chk("par_err_pulse", 64'({key_err_p, sk_valid_p, key_ready_p}), 64'b101);
    @(posedge clk); #1;
    chk("par_err_clear", 64'({key_err_p, sk_valid_p, key_ready_p}), 64'b001);
    key_p = KEY_A; key_valid_p = 1'b1;
    @(posedge clk); #1;
    key_valid_p = 1'b0;
    chk("par_good_accept", 64'({key_err_p, sk_valid_p, sk_round_p}), 64'h10);
    chk("par_good_k1", 64'(subkey_p), 64'(K1_A));
    sk_ready_p = 1'b1;
    cyc = 0;
    while (!key_ready_p && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("par_good_drain", 64'(cyc), 64'd16);
    sk_ready_p = 1'b0;

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
